// File: rtl/frame_assemble.sv
// frame_assemble
// Transmit-side serializer for the optical link. Takes stereo 20-bit samples
// with 4-bit aux words plus a 184-bit channel-status word. It emits one serial
// bit per bit_tick as 28-bit subframes laid out as
//   AUX4 | DATA20 | VALID | USER | CHANNEL | PARITY
// Each frame is a ch0 subframe followed by a ch1 subframe. A block is
// NUM_FRAMES frames. The last 8 channel-status bits of every block carry a
// CRC-8 of the 23 payload bytes.
//
// Ports
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   bit_tick      in   1-cycle strobe: emit the next serial bit
//   pair_valid    in   stereo pair offered
//   pair_ready    out  1-entry pair buffer is empty
//   l_data/r_data in   ch0/ch1 20-bit samples, MSB sent first
//   l_aux/r_aux   in   ch0/ch1 4-bit aux words, MSB sent first
//   cs_word       in   channel-status payload, bit 183 first, sampled at block start
//   dout          out  serial bit
//   vout          out  dout valid, one pulse per bit_tick
//   frame_counter out  frame index of the current dout bit
//   out_channel   out  subframe (0 = ch0, 1 = ch1) of the current dout bit
//   block_start   out  pulses with vout on bit 0 of frame 0, ch0
//
// Handshake: a stereo pair moves into the buffer on any clk edge where
// pair_valid && pair_ready. pair_ready is low while the buffer holds a pair.
// The buffer is consumed at the bit-0 ch0 tick of each frame. An empty buffer
// at that tick sends a zero frame with VALID=1.

module frame_assemble #(
    parameter logic [7:0] CRC_POLY   = 8'h1D,
    parameter logic [7:0] CRC_INIT   = 8'hFF,
    parameter int         NUM_FRAMES = 192
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bit_tick,
    input  logic                    pair_valid,
    output logic                    pair_ready,
    input  logic [19:0]             l_data,
    input  logic [19:0]             r_data,
    input  logic [3:0]              l_aux,
    input  logic [3:0]              r_aux,
    input  logic [NUM_FRAMES-9:0]   cs_word,
    output logic                    dout,
    output logic                    vout,
    output logic [7:0]              frame_counter,
    output logic                    out_channel,
    output logic                    block_start
);

    localparam int CS_BITS    = NUM_FRAMES - 8;
    localparam int LAST_FRAME = NUM_FRAMES - 1;

    // The CRC register is kept in reflected form (shift right), so the
    // polynomial is bit-reversed and the register already holds the
    // reflected-out result.
    localparam logic [7:0] POLY_REF = {CRC_POLY[0], CRC_POLY[1], CRC_POLY[2], CRC_POLY[3],
                                       CRC_POLY[4], CRC_POLY[5], CRC_POLY[6], CRC_POLY[7]};

    typedef enum logic [2:0] {
        FLD_AUX,
        FLD_DATA,
        FLD_VALID,
        FLD_USER,
        FLD_CHANNEL,
        FLD_PARITY
    } field_e;

    // Position of the next bit to send.
    logic [4:0]  bit_cnt;
    logic        chan_q;
    logic [7:0]  frame_q;
    field_e      field;

    // One-entry pair buffer.
    logic        buf_full;
    logic [19:0] buf_l_data, buf_r_data;
    logic [3:0]  buf_l_aux, buf_r_aux;

    // Pair being sent in the current frame.
    logic [19:0] fr_l_data, fr_r_data;
    logic [3:0]  fr_l_aux, fr_r_aux;
    logic        fr_valid;

    logic [CS_BITS-1:0] cs_latched;
    logic [7:0]  crc_q;
    logic [6:0]  crc_byte_sr;

    // Frame contents as seen by the bit now being sent.
    logic        frame_start;
    logic [19:0] sel_l_data, sel_r_data;
    logic [3:0]  sel_l_aux, sel_r_aux;
    logic        sel_valid;
    logic [23:0] payload;
    logic [4:0]  payload_idx;
    logic [7:0]  cs_idx;
    logic [2:0]  crc_idx;
    logic        chan_bit;
    logic        parity_bit;
    logic        tx_bit;

    function automatic logic [7:0] crc_step(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] r;
        logic       fb;
        r = crc_in;
        // Reflected input: the byte LSB (last bit on the wire) is fed first.
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ data[i];
            r  = {1'b0, r[7:1]};
            if (fb) begin
                r = r ^ POLY_REF;
            end
        end
        return r;
    endfunction

    assign pair_ready  = ~buf_full;
    assign frame_start = (bit_cnt == 5'd0) && !chan_q;

    always_comb begin
        field = FLD_PARITY;
        if (bit_cnt <= 5'd3) begin
            field = FLD_AUX;
        end else if (bit_cnt <= 5'd23) begin
            field = FLD_DATA;
        end else if (bit_cnt == 5'd24) begin
            field = FLD_VALID;
        end else if (bit_cnt == 5'd25) begin
            field = FLD_USER;
        end else if (bit_cnt == 5'd26) begin
            field = FLD_CHANNEL;
        end
    end

    // At the bit-0 ch0 tick the frame registers have not been loaded yet, so
    // that bit is taken straight from the buffer (or zeros on underrun).
    always_comb begin
        sel_l_data = fr_l_data;
        sel_r_data = fr_r_data;
        sel_l_aux  = fr_l_aux;
        sel_r_aux  = fr_r_aux;
        sel_valid  = fr_valid;
        if (frame_start) begin
            if (buf_full) begin
                sel_l_data = buf_l_data;
                sel_r_data = buf_r_data;
                sel_l_aux  = buf_l_aux;
                sel_r_aux  = buf_r_aux;
                sel_valid  = 1'b0;
            end else begin
                sel_l_data = '0;
                sel_r_data = '0;
                sel_l_aux  = '0;
                sel_r_aux  = '0;
                sel_valid  = 1'b1;
            end
        end
    end

    always_comb begin
        payload     = chan_q ? {sel_r_aux, sel_r_data} : {sel_l_aux, sel_l_data};
        payload_idx = 5'd23 - bit_cnt;
        cs_idx      = 8'(CS_BITS - 1) - frame_q;
        crc_idx     = 3'(LAST_FRAME) - frame_q[2:0];
        // Payload frames carry the latched status word; the tail carries the CRC, MSB first.
        chan_bit    = (frame_q < 8'(CS_BITS)) ? cs_latched[cs_idx] : crc_q[crc_idx];
        // USER is always 0, so it drops out of the parity.
        parity_bit  = ^payload ^ sel_valid ^ chan_bit;
        tx_bit      = 1'b0;
        case (field)
            FLD_AUX,
            FLD_DATA:    tx_bit = payload[payload_idx];
            FLD_VALID:   tx_bit = sel_valid;
            FLD_USER:    tx_bit = 1'b0;
            FLD_CHANNEL: tx_bit = chan_bit;
            FLD_PARITY:  tx_bit = parity_bit;
            default:     tx_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt       <= '0;
            chan_q        <= 1'b0;
            frame_q       <= '0;
            buf_full      <= 1'b0;
            buf_l_data    <= '0;
            buf_r_data    <= '0;
            buf_l_aux     <= '0;
            buf_r_aux     <= '0;
            fr_l_data     <= '0;
            fr_r_data     <= '0;
            fr_l_aux      <= '0;
            fr_r_aux      <= '0;
            fr_valid      <= 1'b0;
            cs_latched    <= '0;
            crc_q         <= CRC_INIT;
            crc_byte_sr   <= '0;
            dout          <= 1'b0;
            vout          <= 1'b0;
            frame_counter <= '0;
            out_channel   <= 1'b0;
            block_start   <= 1'b0;
        end else begin
            if (pair_valid && pair_ready) begin
                buf_full   <= 1'b1;
                buf_l_data <= l_data;
                buf_r_data <= r_data;
                buf_l_aux  <= l_aux;
                buf_r_aux  <= r_aux;
            end

            if (bit_tick) begin
                dout          <= tx_bit;
                vout          <= 1'b1;
                frame_counter <= frame_q;
                out_channel   <= chan_q;
                block_start   <= frame_start && (frame_q == 8'd0);

                if (frame_start) begin
                    fr_l_data <= sel_l_data;
                    fr_r_data <= sel_r_data;
                    fr_l_aux  <= sel_l_aux;
                    fr_r_aux  <= sel_r_aux;
                    fr_valid  <= sel_valid;
                    // No transfer can land this cycle while full, so this clear never races one.
                    if (buf_full) begin
                        buf_full <= 1'b0;
                    end
                    if (frame_q == 8'd0) begin
                        cs_latched <= cs_word;
                        crc_q      <= CRC_INIT;
                    end
                end

                // Gather ch0 status bits into bytes (first bit = MSB) and fold each
                // complete byte into the CRC on its eighth bit.
                if (field == FLD_CHANNEL && !chan_q && frame_q < 8'(CS_BITS)) begin
                    crc_byte_sr <= {crc_byte_sr[5:0], chan_bit};
                    if (frame_q[2:0] == 3'd7) begin
                        crc_q <= crc_step(crc_q, {crc_byte_sr, chan_bit});
                    end
                end

                if (bit_cnt == 5'd27) begin
                    bit_cnt <= '0;
                    chan_q  <= ~chan_q;
                    if (chan_q) begin
                        frame_q <= (frame_q == 8'(LAST_FRAME)) ? 8'd0 : frame_q + 8'd1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end else begin
                vout        <= 1'b0;
                block_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_assemble.sv
// tb_frame_assemble
// Drives frame_assemble with pair traffic, channel-status words, tick gaps and
// a mid-frame reset. The bench builds the expected serial stream for each
// frame from its own model. Each expected bit is packed as
// {block_start, frame_counter, out_channel, dout} and pushed to exp_q when its
// tick is driven. The entry is popped and compared when vout shows it.

module tb_frame_assemble;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         bit_tick;
    logic         pair_valid;
    logic         pair_ready;
    logic [19:0]  l_data, r_data;
    logic [3:0]   l_aux, r_aux;
    logic [183:0] cs_word;
    logic         dout, vout, out_channel, block_start;
    logic [7:0]   frame_counter;

    always #5 clk = ~clk;

    frame_assemble dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bit_tick     (bit_tick),
        .pair_valid   (pair_valid),
        .pair_ready   (pair_ready),
        .l_data       (l_data),
        .r_data       (r_data),
        .l_aux        (l_aux),
        .r_aux        (r_aux),
        .cs_word      (cs_word),
        .dout         (dout),
        .vout         (vout),
        .frame_counter(frame_counter),
        .out_channel  (out_channel),
        .block_start  (block_start)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          bs_count = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_e;
    logic        exp_vout = 1'b0;

    // Model state: pair waiting in the DUT buffer, current block, frame index.
    logic         m_has;
    logic [19:0]  m_l, m_r;
    logic [3:0]   m_la, m_ra;
    logic [183:0] m_cs;
    logic [7:0]   m_crc;
    int           m_frame;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] reflect8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Textbook CRC-8: reflect each input byte, MSB-first shift-left division by
    // 0x1D from init 0xFF, reflect the final register.
    function automatic logic [7:0] ref_crc(input logic [183:0] cs);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'hFF;
        for (int k = 0; k < 23; k++) begin
            b = cs[183 - 8*k -: 8];
            c = c ^ reflect8(b);
            for (int j = 0; j < 8; j++) begin
                c = c[7] ? ((c << 1) ^ 8'h1D) : (c << 1);
            end
        end
        return reflect8(c);
    endfunction

    // Cycle budget: vout must follow exactly the cycles where a tick was sampled outside reset.
    always @(posedge clk) exp_vout <= bit_tick && rst_n;

    always @(negedge clk) begin
        check("vout", 32'(vout), 32'(exp_vout));
        if (vout) begin
            check("pending_bits", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("bit{bs,frame,ch,dout}",
                      32'({block_start, frame_counter, out_channel, dout}), 32'(mon_e));
                if (block_start) bs_count++;
            end
        end
    end

    task automatic set_pair(input logic [19:0] ld, input logic [19:0] rd,
                            input logic [3:0] la, input logic [3:0] ra);
        pair_valid = 1'b1;
        l_data = ld;
        r_data = rd;
        l_aux  = la;
        r_aux  = ra;
        m_has = 1'b1;
        m_l = ld;
        m_r = rd;
        m_la = la;
        m_ra = ra;
    endtask

    task automatic tick_gap(input int gap_max);
        int g;
        g = $urandom_range(gap_max, 0);
        if (g > 0) begin
            bit_tick = 1'b0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Send the first n_bits of the next frame. When load_next is set, a new
    // random pair is offered at bit 1, so it is buffered for the following frame.
    task automatic run_frame(input bit load_next, input int gap_max, input int n_bits);
        logic [10:0] fb[56];
        logic [27:0] sf;
        logic [3:0]  aux_v[2];
        logic [19:0] dat_v[2];
        logic        v, c;
        if (m_frame == 0) begin
            m_cs  = cs_word;
            m_crc = ref_crc(cs_word);
        end
        if (m_has) begin
            aux_v[0] = m_la; aux_v[1] = m_ra;
            dat_v[0] = m_l;  dat_v[1] = m_r;
        end else begin
            aux_v[0] = '0; aux_v[1] = '0;
            dat_v[0] = '0; dat_v[1] = '0;
        end
        v = !m_has;
        m_has = 1'b0;
        c = (m_frame < 184) ? m_cs[183 - m_frame] : m_crc[191 - m_frame];
        for (int ch = 0; ch < 2; ch++) begin
            sf = {aux_v[ch], dat_v[ch], v, 1'b0, c, 1'b0};
            sf[0] = ^sf[27:1];
            for (int i = 0; i < 28; i++) begin
                fb[ch*28 + i] = {(m_frame == 0 && ch == 0 && i == 0), 8'(m_frame), ch[0], sf[27-i]};
            end
        end
        for (int b = 0; b < n_bits; b++) begin
            if (b == 1 && load_next) begin
                check("ready_mid_frame", 32'(pair_ready), 32'd1);
                set_pair(20'($urandom), 20'($urandom), 4'($urandom), 4'($urandom));
            end
            exp_q.push_back(fb[b]);
            bit_tick = 1'b1;
            @(posedge clk);
            #1;
            pair_valid = 1'b0;
            tick_gap(gap_max);
        end
        if (n_bits == 56) m_frame = (m_frame == 191) ? 0 : m_frame + 1;
    endtask

    initial begin
        rst_n = 1'b0;
        bit_tick = 1'b0;
        pair_valid = 1'b0;
        l_data = '0; r_data = '0; l_aux = '0; r_aux = '0;
        cs_word = 184'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        m_has = 1'b0;
        m_frame = 0;
        m_cs = '0;
        m_crc = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_dout", 32'(dout), 32'd0);
        check("rst_vout", 32'(vout), 32'd0);
        check("rst_block_start", 32'(block_start), 32'd0);
        check("rst_frame_counter", 32'(frame_counter), 32'd0);
        check("rst_out_channel", 32'(out_channel), 32'd0);
        check("rst_pair_ready", 32'(pair_ready), 32'd1);

        // Block A: first frame carries ABCDE / aux 9; frame 1 is an underrun.
        set_pair(20'hABCDE, 20'($urandom), 4'h9, 4'($urandom));
        @(posedge clk);
        #1;
        pair_valid = 1'b0;
        check("ready_after_load", 32'(pair_ready), 32'd0);
        for (int f = 0; f < 192; f++) begin
            run_frame((f == 0) ? 1'b0 : ($urandom_range(3, 0) != 0), (f % 3 == 0) ? 0 : 1, 56);
        end

        // Block B: all-zero status word at full tick rate.
        bs_count = 0;
        cs_word = '0;
        for (int f = 0; f < 192; f++) begin
            run_frame($urandom_range(3, 0) != 0, 0, 56);
        end
        check("block_start_count_one_block", 32'(bs_count), 32'd1);

        // Block C: run into frame 57, then reset at bit 13 with a pair buffered.
        cs_word = 184'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        for (int f = 0; f < 57; f++) begin
            run_frame($urandom_range(3, 0) != 0, 1, 56);
        end
        check("block_start_count_next_block", 32'(bs_count), 32'd2);
        run_frame(1'b1, 1, 13);
        check("ready_full_before_reset", 32'(pair_ready), 32'd0);
        bit_tick = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bit_tick = 1'b0;
        check("reset_mid_vout", 32'(vout), 32'd0);
        check("reset_mid_ready", 32'(pair_ready), 32'd1);
        check("reset_mid_frame_counter", 32'(frame_counter), 32'd0);
        check("reset_mid_out_channel", 32'(out_channel), 32'd0);
        m_has = 1'b0;
        m_frame = 0;
        @(posedge clk);
        #1;
        run_frame(1'b1, 0, 56);
        run_frame(1'b0, 0, 56);
        bit_tick = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
